// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the AXI-Stream switch output-port scheduler.
package axis_switch_pkg;

    // Scheduler FSM: IDLE picks a source, LOCK holds it until the tlast beat.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Index width for n sources; a single source still needs a 1-bit index.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AXIS_N_IN   = 8;
    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_ID_W   = id_width(AXIS_N_IN);

    // One registered output beat.
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   last;
        logic [AXIS_ID_W-1:0]   id;
    } axis_beat_t;

endpackage

// File: rtl/irr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer
// moves past the winner only when the consumer takes the grant.
module irr_arbiter
    import axis_switch_pkg::*;
#(
    parameter int WIDTH_REQ = 8,
    parameter int ID_W      = id_width(WIDTH_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH_REQ-1:0] req_i,
    input  logic                 gnt_rdy_i,
    output logic                 gnt_vld_o,
    output logic [ID_W-1:0]      gnt_id_o
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] idx;

    // Scan from the pointer upward with wrap; the lowest offset wins.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_id_o  = '0;
        idx       = '0;
        for (int off = WIDTH_REQ - 1; off >= 0; off--) begin
            idx = ID_W'((int'(ptr_q) + off) % WIDTH_REQ);
            if (req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_id_o  = idx;
            end
        end
    end

    // Advance the pointer one past the winner, wrapping at WIDTH_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_rdy_i && gnt_vld_o) begin
            ptr_d = ID_W'((int'(gnt_id_o) + 1) % WIDTH_REQ);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axis_switch_port_sched.sv
// Output-port scheduler: shares one AXI-Stream master between N_IN slaves,
// holding the arbiter grant for a whole packet behind a one-stage output register.
module axis_switch_port_sched
    import axis_switch_pkg::*;
#(
    parameter int N_IN   = AXIS_N_IN,
    parameter int DATA_W = AXIS_DATA_W,
    parameter int ID_W   = id_width(N_IN),
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_IN*DATA_W-1:0]   s_tdata_i,
    input  logic [N_IN-1:0]          s_tvalid_i,
    input  logic [N_IN-1:0]          s_tlast_i,
    output logic [N_IN-1:0]          s_tready_o,
    output logic [DATA_W-1:0]        m_tdata_o,
    output logic                     m_tvalid_o,
    output logic                     m_tlast_o,
    output logic [ID_W-1:0]          m_tid_o,
    input  logic                     m_tready_i,
    input  logic [N_IN-1:0]          port_en_i,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         pkt_cnt_o
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  sel_q, sel_d;
    axis_beat_t       beat_q, beat_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] lane_data [N_IN];
    logic [N_IN-1:0]   req;
    logic [N_IN-1:0]   tready;
    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_id;
    logic              adv;

    for (genvar g = 0; g < N_IN; g++) begin : g_lane
        assign lane_data[g] = s_tdata_i[g*DATA_W +: DATA_W];
    end

    // The output register can take a new beat when empty or being drained.
    assign adv = ~vld_q | m_tready_i;
    assign req = s_tvalid_i & port_en_i;

    irr_arbiter #(
        .WIDTH_REQ (N_IN),
        .ID_W      (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req),
        .gnt_rdy_i (state_q == IDLE),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    // Next-state, output-register load and packet counter.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        beat_d  = beat_q;
        vld_d   = vld_q;
        tready  = '0;
        cnt_d   = cnt_q;

        if (vld_q && m_tready_i && beat_q.last) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Drain the register when it moves on and nothing refills it.
        if (adv) begin
            vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    sel_d   = gnt_id;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                tready[sel_q] = adv;
                if (s_tvalid_i[sel_q] && adv) begin
                    beat_d.data = lane_data[sel_q];
                    beat_d.last = s_tlast_i[sel_q];
                    beat_d.id   = sel_q;
                    vld_d       = 1'b1;
                    if (s_tlast_i[sel_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, selection, output register and counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            beat_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_tready_o = tready;
    assign m_tdata_o  = beat_q.data;
    assign m_tlast_o  = beat_q.last;
    assign m_tid_o    = beat_q.id;
    assign m_tvalid_o = vld_q;
    assign busy_o     = (state_q == LOCK);
    assign pkt_cnt_o  = cnt_q;

    a_tready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(s_tready_o));

    a_tready_busy: assert property (@(posedge clk) disable iff (!reset_n)
        (|s_tready_o) |-> busy_o);

    a_data_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (m_tvalid_o && !m_tready_i) |=> $stable(m_tdata_o));

    a_tid_sel: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == LOCK && s_tvalid_i[sel_q] && adv) |=> (m_tid_o == $past(sel_q)));

endmodule
